icache_ds_txn_tracker: RTL
==========================

Name: icache_ds_txn_tracker

Overview:
- Sits between the icache MSHR and the downstream (L2/bus) port.
- Accepts line-fill requests from MSHR entries and allocates a downstream transaction ID from a free pool. Issues a registered downstream read request.
- Matches returning downstream data to the owning MSHR entry by txnid. Hands the refill (entry_idx, lineA, 512-bit line) to the MSHR/data-RAM write path, then recycles the txnid.

Parameters:
- TXN_NUM, 16: outstanding downstream transactions; must be ≤ 2**ICACHE_REQ_TXNID_WIDTH (32).
- TIMEOUT_CYC, 1023: cycles before timeout flag (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mshr_req_vld  in  1  MSHR fill request valid
- mshr_req_rdy  out  1  request accepted when vld&rdy
- mshr_req_line_addr  in  26  tag+index (ADDR_WIDTH-ICACHE_OFFSET_WIDTH)
- mshr_req_entry_idx  in  4  MSHR entry (MSHR_ENTRY_INDEX_WIDTH)
- mshr_req_lineA  in  1  A/B half of the entry
- ds_txreq_vld  out  1  downstream request valid
- ds_txreq_rdy  in  1  downstream accept
- ds_txreq_addr  out  32  {line_addr, 6'b0}
- ds_txreq_opcode  out  5  always DOWNSTREAM_OPCODE (1)
- ds_txreq_txnid  out  5  allocated txnid
- ds_rxdat_vld  in  1  downstream data valid
- ds_rxdat_rdy  out  1  data accept
- ds_rxdat_opcode  in  5  ignored except in error check
- ds_rxdat_txnid  in  5  returning txnid
- ds_rxdat_data  in  512  line data
- refill_vld  out  1  refill valid
- refill_rdy  in  1  refill accept
- refill_pld  out  downstream_rxdat_t  opcode, txnid, data, entry_idx, lineA
- outstanding_cnt  out  5  slots allocated ($clog2(TXN_NUM+1))
- err_unexp_txnid  out  1  one-cycle pulse: rxdat txnid not allocated

Behaviour:
- Reset values: all valids 0, mshr_req_rdy 0 during reset, free vector all-ones, outstanding_cnt 0, err 0. Table contents are don't-care.
- Slot table per txnid: alloc bit, entry_idx, lineA.

Request path:
- mshr_req_rdy = (any free slot) & (txreq output register empty | ds_txreq_rdy).
- On accept, allocate the lowest free index using the free vector sampled at the start of the cycle. Write the table.
- Load the output register; ds_txreq_vld asserts the next cycle (1-cycle latency).
- Output register holds stable while vld & !rdy.
- Back-to-back accepts are allowed when ds_txreq_rdy = 1 (throughput 1/cycle).

Response path:
- One-entry refill output register.
- ds_rxdat_rdy = refill register empty | refill_rdy.
- On rxdat handshake, look up the table by txnid. If the slot is allocated, load the refill register with entry_idx, lineA, txnid, opcode and data. refill_vld asserts the next cycle.
- If the slot is not allocated (or txnid ≥ TXN_NUM): accept and drop the beat, pulse err_unexp_txnid for 1 cycle, table unchanged.
- Slot is freed on the refill handshake (refill_vld & refill_rdy), not on rxdat arrival.

Simultaneous events:
- Free and alloc in the same cycle: the freed slot is not chosen that cycle; it is reusable next cycle.
- outstanding_cnt = count +alloc −free, both may occur in the same cycle (net 0).
- Full: when TXN_NUM slots are allocated, mshr_req_rdy = 0 until a free occurs. The free cycle itself still shows rdy = 0 (pre-cycle vector).
- Empty: outstanding_cnt = 0. An rxdat in this state is an unexpected txnid.

Reset:
- Reset asserted mid-operation clears all valids and frees all slots immediately. In-flight downstream responses after reset are treated as unexpected.

Optional Feature:
- Macro ICACHE_DS_TIMEOUT_EN.
- Defined:
  - Per-slot 10-bit age counter, cleared on alloc, increments while allocated, saturates at TIMEOUT_CYC.
  - Extra output err_timeout (1 bit) pulses for 1 cycle when any slot first reaches TIMEOUT_CYC.
  - The slot is not freed by the timeout.
- Undefined: no counters, no err_timeout port.

Test Plan:
- Single fill: req line_addr 0x0123456, entry 3, lineA 1 -> next cycle ds_txreq addr 0x048D1580, opcode 1, txnid 0. rxdat txnid 0, data 0xA5.. -> refill entry_idx 3, lineA 1, data 0xA5..; outstanding_cnt 1 → 0.
- Fill to full: 16 reqs with ds_txreq_rdy = 1 -> txnids 0..15 in order, outstanding_cnt 16, mshr_req_rdy 0. Return txnid 7 and accept its refill -> next request gets txnid 7.
- Out-of-order returns: txnids 2, 0, 1 returned -> refills carry each slot's own entry_idx. Holding refill_rdy = 0 for 5 cycles keeps ds_rxdat_rdy = 0 and the payload stable.
- Unexpected txnid: rxdat txnid 9 with no allocation -> err_unexp_txnid pulses once, no refill_vld.
- Backpressure: ds_txreq_rdy = 0 for 4 cycles -> txreq payload stable and mshr_req_rdy = 0. Release -> one txreq per cycle.
- With ICACHE_DS_TIMEOUT_EN, TIMEOUT_CYC = 20: allocate, no response -> err_timeout pulses 20 cycles after the allocate, exactly once.

Source files
------------

// File: rtl/icache_ds_txn_tracker_pkg.sv
// Types shared by the icache downstream transaction tracker and its users.
//   downstream_rxdat_t : refill payload handed to the MSHR / data-RAM write path
package icache_ds_txn_tracker_pkg;

   localparam int unsigned ADDR_WIDTH             = 32;
   localparam int unsigned ICACHE_OFFSET_WIDTH    = 6;
   localparam int unsigned LINE_ADDR_WIDTH        = ADDR_WIDTH - ICACHE_OFFSET_WIDTH;
   localparam int unsigned MSHR_ENTRY_INDEX_WIDTH = 4;
   localparam int unsigned ICACHE_REQ_TXNID_WIDTH = 5;
   localparam int unsigned DS_OPCODE_WIDTH        = 5;
   localparam int unsigned LINE_DATA_WIDTH        = 512;

   localparam logic [DS_OPCODE_WIDTH-1:0] DOWNSTREAM_OPCODE = DS_OPCODE_WIDTH'(1);

   typedef struct packed {
      logic [DS_OPCODE_WIDTH-1:0]        opcode;
      logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
      logic [LINE_DATA_WIDTH-1:0]        data;
      logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
      logic                              lineA;
   } downstream_rxdat_t;

endpackage

// File: rtl/icache_ds_txn_tracker.sv
// icache downstream transaction tracker.
// Allocates a downstream txnid per MSHR line-fill request, issues a registered
// downstream read, matches returning data to the owning MSHR entry by txnid and
// hands the refill onward; the txnid is recycled on the refill handshake.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mshr_req_*                fill request from MSHR (vld/rdy, line_addr, entry_idx, lineA)
//   ds_txreq_*                downstream read request (vld/rdy, addr, opcode, txnid)
//   ds_rxdat_*                downstream data return (vld/rdy, opcode, txnid, data)
//   refill_vld/rdy/pld        refill toward MSHR / data RAM
//   outstanding_cnt           number of allocated txnids
//   err_unexp_txnid           1-cycle pulse: returned txnid not allocated
//   err_timeout               (ICACHE_DS_TIMEOUT_EN only) 1-cycle pulse when a slot
//                             first reaches TIMEOUT_CYC cycles of age
//
// Build option: define ICACHE_DS_TIMEOUT_EN to add per-slot age counters and err_timeout.
module icache_ds_txn_tracker
   import icache_ds_txn_tracker_pkg::*;
#(
   parameter int unsigned TXN_NUM     = 16,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              mshr_req_vld,
   output logic                              mshr_req_rdy,
   input  logic [LINE_ADDR_WIDTH-1:0]        mshr_req_line_addr,
   input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] mshr_req_entry_idx,
   input  logic                              mshr_req_lineA,
   output logic                              ds_txreq_vld,
   input  logic                              ds_txreq_rdy,
   output logic [ADDR_WIDTH-1:0]             ds_txreq_addr,
   output logic [DS_OPCODE_WIDTH-1:0]        ds_txreq_opcode,
   output logic [ICACHE_REQ_TXNID_WIDTH-1:0] ds_txreq_txnid,
   input  logic                              ds_rxdat_vld,
   output logic                              ds_rxdat_rdy,
   input  logic [DS_OPCODE_WIDTH-1:0]        ds_rxdat_opcode,
   input  logic [ICACHE_REQ_TXNID_WIDTH-1:0] ds_rxdat_txnid,
   input  logic [LINE_DATA_WIDTH-1:0]        ds_rxdat_data,
   output logic                              refill_vld,
   input  logic                              refill_rdy,
   output downstream_rxdat_t                 refill_pld,
   output logic [$clog2(TXN_NUM+1)-1:0]      outstanding_cnt,
   output logic                              err_unexp_txnid
`ifdef ICACHE_DS_TIMEOUT_EN
   ,
   output logic                              err_timeout
`endif
);

   localparam int unsigned IDX_W   = (TXN_NUM > 1) ? $clog2(TXN_NUM) : 1;
   localparam int unsigned CNT_W   = $clog2(TXN_NUM + 1);
   localparam int unsigned TXNID_W = ICACHE_REQ_TXNID_WIDTH;
   localparam int unsigned AGE_W   = 10;

   // Elaboration-time parameter sanity
   if (TXN_NUM < 1 || TXN_NUM > (1 << TXNID_W)) begin : g_bad_txn_num
      $error("TXN_NUM must be in 1..2**ICACHE_REQ_TXNID_WIDTH");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << AGE_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYC must fit the 10-bit age counter");
   end

   logic [TXN_NUM-1:0]                alloc_q;
   logic [MSHR_ENTRY_INDEX_WIDTH-1:0] tbl_entry_q [TXN_NUM];
   logic                              tbl_lineA_q [TXN_NUM];

   logic                              txreq_vld_q;
   logic [LINE_ADDR_WIDTH-1:0]        txreq_line_q;
   logic [TXNID_W-1:0]                txreq_txnid_q;

   logic                              refill_vld_q;
   downstream_rxdat_t                 refill_pld_q;

   logic [CNT_W-1:0]                  cnt_q;
   logic                              err_unexp_q;

   // Lowest free slot from the start-of-cycle vector; a slot freed this cycle stays
   // marked allocated here, so it can only be reused next cycle.
   logic             any_free;
   logic [IDX_W-1:0] free_idx;
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = 0; i < int'(TXN_NUM); i++) begin
         if (!alloc_q[i] && !any_free) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   logic req_fire;
   logic refill_fire;
   logic rx_fire;
   logic rx_hit;
   logic rx_freeing;
   logic [31:0]      alloc_pad;
   logic [IDX_W-1:0] rx_idx;
   logic [IDX_W-1:0] rel_idx;

   assign mshr_req_rdy = ~rst & any_free & (~txreq_vld_q | ds_txreq_rdy);
   assign req_fire     = mshr_req_vld & mshr_req_rdy;
   assign refill_fire  = refill_vld_q & refill_rdy;
   assign ds_rxdat_rdy = ~rst & (~refill_vld_q | refill_rdy);
   assign rx_fire      = ds_rxdat_vld & ds_rxdat_rdy;

   // Zero-padded view so any 5-bit txnid indexes safely; ids >= TXN_NUM read as free.
   assign alloc_pad  = 32'(alloc_q);
   assign rx_idx     = ds_rxdat_txnid[IDX_W-1:0];
   assign rel_idx    = refill_pld_q.txnid[IDX_W-1:0];
   // A repeat of the txnid being released this very cycle is a stray beat.
   assign rx_freeing = refill_fire && (refill_pld_q.txnid == ds_rxdat_txnid);
   assign rx_hit     = alloc_pad[ds_rxdat_txnid] & ~rx_freeing;

   // One-hot set/clear masks for the slot vector
   logic [TXN_NUM-1:0] alloc_set;
   logic [TXN_NUM-1:0] alloc_clr;
   always_comb begin
      alloc_set = '0;
      alloc_clr = '0;
      if (req_fire)    alloc_set[free_idx] = 1'b1;
      if (refill_fire) alloc_clr[rel_idx]  = 1'b1;
   end

   // Slot vector, occupancy count and unexpected-txnid pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alloc_q     <= '0;
         cnt_q       <= '0;
         err_unexp_q <= 1'b0;
      end else begin
         alloc_q     <= (alloc_q | alloc_set) & ~alloc_clr;
         cnt_q       <= cnt_q + CNT_W'(req_fire) - CNT_W'(refill_fire);
         err_unexp_q <= rx_fire & ~rx_hit;
      end
   end

   // Slot table: owner of each txnid; contents only meaningful while allocated
   always_ff @(posedge clk) begin
      if (req_fire) begin
         tbl_entry_q[free_idx] <= mshr_req_entry_idx;
         tbl_lineA_q[free_idx] <= mshr_req_lineA;
      end
   end

   // Downstream request output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txreq_vld_q <= 1'b0;
      end else if (req_fire) begin
         txreq_vld_q <= 1'b1;
      end else if (ds_txreq_rdy) begin
         txreq_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) begin
         txreq_line_q  <= mshr_req_line_addr;
         txreq_txnid_q <= TXNID_W'(free_idx);
      end
   end

   // Refill output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refill_vld_q <= 1'b0;
      end else if (rx_fire && rx_hit) begin
         refill_vld_q <= 1'b1;
      end else if (refill_rdy) begin
         refill_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_fire && rx_hit) begin
         refill_pld_q.opcode    <= ds_rxdat_opcode;
         refill_pld_q.txnid     <= ds_rxdat_txnid;
         refill_pld_q.data      <= ds_rxdat_data;
         refill_pld_q.entry_idx <= tbl_entry_q[rx_idx];
         refill_pld_q.lineA     <= tbl_lineA_q[rx_idx];
      end
   end

`ifdef ICACHE_DS_TIMEOUT_EN
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYC);

   logic [AGE_W-1:0] age_q [TXN_NUM];
   logic             err_timeout_q;
   logic             to_hit;

   // A slot crosses into timeout on this edge (and is not being released)
   always_comb begin
      to_hit = 1'b0;
      for (int i = 0; i < int'(TXN_NUM); i++) begin
         if (alloc_q[i] && !alloc_clr[i] && (age_q[i] == AGE_MAX - AGE_W'(1))) begin
            to_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(TXN_NUM); i++) age_q[i] <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(TXN_NUM); i++) begin
            if (alloc_set[i]) begin
               age_q[i] <= '0;
            end else if (alloc_q[i] && (age_q[i] != AGE_MAX)) begin
               age_q[i] <= age_q[i] + AGE_W'(1);
            end
         end
         err_timeout_q <= to_hit;
      end
   end

   assign err_timeout = err_timeout_q;
`endif

   assign ds_txreq_vld    = txreq_vld_q;
   assign ds_txreq_addr   = {txreq_line_q, ICACHE_OFFSET_WIDTH'(0)};
   assign ds_txreq_opcode = DOWNSTREAM_OPCODE;
   assign ds_txreq_txnid  = txreq_txnid_q;
   assign refill_vld      = refill_vld_q;
   assign refill_pld      = refill_pld_q;
   assign outstanding_cnt = cnt_q;
   assign err_unexp_txnid = err_unexp_q;

endmodule
